cache_sa2: RTL and testbench

- Parametrised 2-way set-associative, write-back, write-allocate cache with true-LRU replacement per set.
- Successor to the team's direct-mapped processor cache.
- Sits between the processor word interface (30-bit word address, 32-bit data) and the 128-bit block memory interface with `mem_ready` handshake.
- Block size is fixed at 4 words; set count and tag width scale with `SET_W`.

---
 rtl/cache_sa2.sv | 234 +++++++++++++++++++++++
 tb/tb_cache_sa2.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_sa2.sv
// -----------------------------------------------------------------------------
// cache_sa2 : 2-way set-associative, write-back, write-allocate cache with
//             one true-LRU bit per set. Block size is 4 words of 32 bits.
//
// Optional feature macro: CACHE_PERF_CNT_EN
//   When defined, hit/miss performance counters perf_hit / perf_miss are added.
//
// Parameters
//   SET_W   log2 of the number of sets (sets = 2**SET_W, lines = 2 * sets)
//   ADDR_W  processor word-address width
//
// Ports
//   clk           rising-edge clock
//   proc_reset_n  synchronous active-low reset
//   proc_read     processor read request (held while proc_stall is high)
//   proc_write    processor write request (held while proc_stall is high)
//   proc_addr     word address: [1:0] word, [SET_W+1:2] set, upper bits tag
//   proc_wdata    processor write data
//   proc_rdata    read data, valid when proc_read=1 and proc_stall=0
//   proc_stall    access not complete yet
//   mem_read      block read request (registered)
//   mem_write     block write request (registered)
//   mem_addr      block address
//   mem_wdata     victim block, word 0 in [31:0]
//   mem_rdata     fill block, word 0 in [31:0]
//   mem_ready     one-cycle completion pulse for the current memory request
//   perf_hit      (CACHE_PERF_CNT_EN only) completed hits, excluding retries
//   perf_miss     (CACHE_PERF_CNT_EN only) misses that started a refill
// -----------------------------------------------------------------------------
module cache_sa2 #(
    parameter int SET_W  = 2,
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
`endif
);

    localparam int TAG_W = ADDR_W - 2 - SET_W;
    localparam int SETS  = 1 << SET_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WB    = 2'd1,
        ST_ALLOC = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_victim;
    logic [31:0]       r_rdata_hold;
    logic [1:0]        r_valid [SETS];
    logic [1:0]        r_dirty [SETS];
    logic              r_lru   [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][2];
    logic [127:0]      r_data  [SETS][2];

    logic [SET_W-1:0]  w_set;
    logic [TAG_W-1:0]  w_tag;
    logic [1:0]        w_word;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_hit;
    logic              w_hit_way;
    logic              w_victim;
    logic              w_req;
    logic              w_idle;
    logic              w_rd_hit;
    logic              w_wr_hit;
    logic              w_fill;
    logic [127:0]      w_hit_line;
    logic [31:0]       w_hit_word;

    assign w_set  = proc_addr[SET_W+1:2];
    assign w_tag  = proc_addr[ADDR_W-1:SET_W+2];
    assign w_word = proc_addr[1:0];

    // Tag compare of both ways; a tag is only ever installed in one way of a set.
    assign w_hit0    = r_valid[w_set][0] && (r_tag[w_set][0] == w_tag);
    assign w_hit1    = r_valid[w_set][1] && (r_tag[w_set][1] == w_tag);
    assign w_hit     = w_hit0 | w_hit1;
    assign w_hit_way = w_hit1;

    assign w_req   = proc_read | proc_write;
    assign w_idle  = (r_state == ST_IDLE);
    // Read wins over write when both are requested.
    assign w_rd_hit = w_idle & proc_read & w_hit;
    assign w_wr_hit = w_idle & proc_write & ~proc_read & w_hit;
    assign w_fill   = (r_state == ST_ALLOC) & mem_ready;

    assign w_hit_line = r_data[w_set][w_hit_way];
    assign w_hit_word = w_hit_line[{w_word, 5'd0} +: 32];

    assign proc_stall = ~w_idle | (w_req & ~w_hit);
    // Zero-wait read data on a hit; otherwise the last returned word is held.
    assign proc_rdata = w_rd_hit ? w_hit_word : r_rdata_hold;

    // Victim choice: first invalid way (way 0 preferred), else the LRU way.
    always_comb begin
        w_victim = 1'b0;
        if (!r_valid[w_set][0]) begin
            w_victim = 1'b0;
        end else if (!r_valid[w_set][1]) begin
            w_victim = 1'b1;
        end else begin
            w_victim = r_lru[w_set];
        end
    end

    // Controller FSM: line state bits, LRU and the registered memory request.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_state      <= ST_IDLE;
            r_victim     <= 1'b0;
            r_rdata_hold <= 32'd0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 128'd0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= 2'b00;
                r_dirty[s] <= 2'b00;
                r_lru[s]   <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_hit || w_wr_hit) begin
                        r_lru[w_set] <= ~w_hit_way;
                        if (w_wr_hit) begin
                            r_dirty[w_set][w_hit_way] <= 1'b1;
                        end
                        if (w_rd_hit) begin
                            r_rdata_hold <= w_hit_word;
                        end
                        r_state <= ST_IDLE;
                    end else if (w_req) begin
                        r_victim <= w_victim;
                        if (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) begin
                            mem_write <= 1'b1;
                            mem_addr  <= {r_tag[w_set][w_victim], w_set};
                            mem_wdata <= r_data[w_set][w_victim];
                            r_state   <= ST_WB;
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= proc_addr[ADDR_W-1:2];
                            r_state  <= ST_ALLOC;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    if (mem_ready) begin
                        mem_write                <= 1'b0;
                        r_dirty[w_set][r_victim] <= 1'b0;
                        mem_read                 <= 1'b1;
                        mem_addr                 <= proc_addr[ADDR_W-1:2];
                        r_state                  <= ST_ALLOC;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_ALLOC: begin
                    if (mem_ready) begin
                        r_valid[w_set][r_victim] <= 1'b1;
                        r_dirty[w_set][r_victim] <= 1'b0;
                        r_lru[w_set]             <= ~r_victim;
                        mem_read                 <= 1'b0;
                        r_state                  <= ST_IDLE;
                    end else begin
                        r_state <= ST_ALLOC;
                    end
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage; contents are don't-care after reset, and a reset
    // edge never modifies a line.
    always_ff @(posedge clk) begin
        if (proc_reset_n) begin
            if (w_wr_hit) begin
                r_data[w_set][w_hit_way][{w_word, 5'd0} +: 32] <= proc_wdata;
            end else if (w_fill) begin
                r_data[w_set][r_victim] <= mem_rdata;
                r_tag[w_set][r_victim]  <= w_tag;
            end
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic r_retry;

    // Hit/miss counters; the first IDLE cycle after a fill is the retry of the
    // missed access and is not counted as a hit.
    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            r_retry   <= 1'b0;
            perf_hit  <= 32'd0;
            perf_miss <= 32'd0;
        end else begin
            r_retry <= w_fill;
            if (w_idle && w_req && !w_hit) begin
                perf_miss <= perf_miss + 32'd1;
            end
            if ((w_rd_hit || w_wr_hit) && !r_retry) begin
                perf_hit <= perf_hit + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_sa2.sv
// -----------------------------------------------------------------------------
// tb_cache_sa2 : table-driven bench for cache_sa2 (default build).
// Each table row is one clock cycle: inputs are applied just after the rising
// edge and outputs are compared on the falling edge. The reset-in-writeback
// corner case is a hand-written sequence after the table.
// -----------------------------------------------------------------------------
module tb_cache_sa2;

    logic         clk;
    logic         proc_reset_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checks = 0;
    int errors = 0;

    cache_sa2 dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .proc_read    (proc_read),
        .proc_write   (proc_write),
        .proc_addr    (proc_addr),
        .proc_wdata   (proc_wdata),
        .proc_rdata   (proc_rdata),
        .proc_stall   (proc_stall),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [29:0]  addr;
        logic [31:0]  wd;
        logic         rdy;
        logic [127:0] mrd;
        logic         e_stall;
        logic         e_mrd;
        logic         e_mwr;
        logic [27:0]  e_maddr;
        logic         c_rdata;
        logic [31:0]  e_rdata;
        logic         c_wd;
        logic [127:0] e_wd;
    } vec_t;

    vec_t vecs [40];
    int   nvec = 0;

    // Fill blocks returned by memory (word3, word2, word1, word0).
    localparam logic [127:0] F1 = {32'hA3A3A3A3, 32'hDEADBEEF, 32'hA1A1A1A1, 32'hA0A0A0A0};
    localparam logic [127:0] F2 = {32'hB3B3B3B3, 32'h22222222, 32'hB1B1B1B1, 32'hB0B0B0B0};
    localparam logic [127:0] F3 = {32'hC3C3C3C3, 32'h33333333, 32'hC1C1C1C1, 32'hC0C0C0C0};
    localparam logic [127:0] F4 = {32'hD3D3D3D3, 32'h44444444, 32'hD1D1D1D1, 32'h40404040};
    // Expected victim blocks: F1 with word2 written, F4 with word2 written.
    localparam logic [127:0] WB1 = {32'hA3A3A3A3, 32'h11111111, 32'hA1A1A1A1, 32'hA0A0A0A0};
    localparam logic [127:0] WB2 = {32'hD3D3D3D3, 32'h66666666, 32'hD1D1D1D1, 32'h40404040};

    task automatic add(input logic rd, input logic wr, input logic [29:0] addr,
                       input logic [31:0] wd, input logic rdy, input logic [127:0] mrd,
                       input logic e_stall, input logic e_mrd, input logic e_mwr,
                       input logic [27:0] e_maddr, input logic c_rdata,
                       input logic [31:0] e_rdata, input logic c_wd,
                       input logic [127:0] e_wd);
        vecs[nvec] = '{rd, wr, addr, wd, rdy, mrd, e_stall, e_mrd, e_mwr,
                       e_maddr, c_rdata, e_rdata, c_wd, e_wd};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [29:0] addr,
                         input logic [31:0] wd, input logic rdy, input logic [127:0] mrd);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        mem_ready  = rdy;
        mem_rdata  = mrd;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- vector table ----------------
        //   rd    wr    addr      wdata         rdy   mrdata  stall mrd   mwr   maddr    c_rd  rdata          c_wd  wdata
        // Scenario 1: cold read miss, fill way0 of set 0
        add(1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 128'h0, 1'b1, 1'b0, 1'b0, 28'h0,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h12, 32'h0,        1'b1, F1,     1'b1, 1'b1, 1'b0, 28'h4,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'h4,  1'b1, 32'hDEADBEEF,  1'b0, 128'h0);
        // Scenario 2: write hit, miss into invalid way1, re-read
        add(1'b0, 1'b1, 30'h12, 32'h11111111, 1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'h4,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h22, 32'h0,        1'b0, 128'h0, 1'b1, 1'b0, 1'b0, 28'h4,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h22, 32'h0,        1'b1, F2,     1'b1, 1'b1, 1'b0, 28'h8,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h22, 32'h0,        1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'h8,  1'b1, 32'h22222222,  1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'h8,  1'b1, 32'h11111111,  1'b0, 128'h0);
        // Scenario 3: touch 0x12, miss 0x32 evicts clean LRU way1, with a wait cycle
        add(1'b1, 1'b0, 30'h12, 32'h0,        1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'h8,  1'b1, 32'h11111111,  1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h32, 32'h0,        1'b0, 128'h0, 1'b1, 1'b0, 1'b0, 28'h8,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h32, 32'h0,        1'b0, 128'h0, 1'b1, 1'b1, 1'b0, 28'hC,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h32, 32'h0,        1'b1, F3,     1'b1, 1'b1, 1'b0, 28'hC,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h32, 32'h0,        1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'hC,  1'b1, 32'h33333333,  1'b0, 128'h0);
        // Scenario 4: dirty eviction of way0 (tag 1) for 0x42
        add(1'b0, 1'b1, 30'h12, 32'h11111111, 1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'hC,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h32, 32'h0,        1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'hC,  1'b1, 32'h33333333,  1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h42, 32'h0,        1'b0, 128'h0, 1'b1, 1'b0, 1'b0, 28'hC,  1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h42, 32'h0,        1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 28'h4,  1'b0, 32'h0,         1'b1, WB1);
        add(1'b1, 1'b0, 30'h42, 32'h0,        1'b1, 128'h0, 1'b1, 1'b0, 1'b1, 28'h4,  1'b0, 32'h0,         1'b1, WB1);
        add(1'b1, 1'b0, 30'h42, 32'h0,        1'b0, 128'h0, 1'b1, 1'b1, 1'b0, 28'h10, 1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h42, 32'h0,        1'b1, F4,     1'b1, 1'b1, 1'b0, 28'h10, 1'b0, 32'h0,         1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h42, 32'h0,        1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'h10, 1'b1, 32'h44444444,  1'b0, 128'h0);
        // mem_ready in IDLE is ignored
        add(1'b0, 1'b0, 30'h0,  32'h0,        1'b1, F1,     1'b0, 1'b0, 1'b0, 28'h10, 1'b0, 32'h0,         1'b0, 128'h0);
        // Read and write together: read wins, write is dropped
        add(1'b1, 1'b1, 30'h42, 32'h55555555, 1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'h10, 1'b1, 32'h44444444,  1'b0, 128'h0);
        add(1'b1, 1'b0, 30'h42, 32'h0,        1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'h10, 1'b1, 32'h44444444,  1'b0, 128'h0);
        // Word 0 of the same line
        add(1'b1, 1'b0, 30'h40, 32'h0,        1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 28'h10, 1'b1, 32'h40404040,  1'b0, 128'h0);

        // ---------------- reset ----------------
        proc_reset_n = 1'b0;
        drive(1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst mem_read",  {127'd0, mem_read},  128'd0);
        chk("rst mem_write", {127'd0, mem_write}, 128'd0);
        chk("rst mem_addr",  {100'd0, mem_addr},  128'd0);
        chk("rst mem_wdata", mem_wdata,           128'd0);
        chk("rst stall",     {127'd0, proc_stall}, 128'd0);
        @(posedge clk);
        #1;
        proc_reset_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].rdy, vecs[i].mrd);
            @(negedge clk);
            chk($sformatf("v%0d stall", i),     {127'd0, proc_stall}, {127'd0, vecs[i].e_stall});
            chk($sformatf("v%0d mem_read", i),  {127'd0, mem_read},   {127'd0, vecs[i].e_mrd});
            chk($sformatf("v%0d mem_write", i), {127'd0, mem_write},  {127'd0, vecs[i].e_mwr});
            chk($sformatf("v%0d mem_addr", i),  {100'd0, mem_addr},   {100'd0, vecs[i].e_maddr});
            if (vecs[i].c_rdata) begin
                chk($sformatf("v%0d rdata", i), {96'd0, proc_rdata}, {96'd0, vecs[i].e_rdata});
            end
            if (vecs[i].c_wd) begin
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wd);
            end
            next_cycle();
        end

        // ---------------- reset during write-back ----------------
        // Make way0 (tag 4) dirty, make it LRU, then miss 0x12 to start WB.
        drive(1'b0, 1'b1, 30'h42, 32'h66666666, 1'b0, 128'h0);
        @(negedge clk);
        chk("s5 wr stall", {127'd0, proc_stall}, 128'd0);
        next_cycle();
        drive(1'b1, 1'b0, 30'h32, 32'h0, 1'b0, 128'h0);
        @(negedge clk);
        chk("s5 touch rdata", {96'd0, proc_rdata}, {96'd0, 32'h33333333});
        next_cycle();
        drive(1'b1, 1'b0, 30'h12, 32'h0, 1'b0, 128'h0);
        @(negedge clk);
        chk("s5 miss stall", {127'd0, proc_stall}, 128'd1);
        next_cycle();
        @(negedge clk);
        chk("s5 wb mem_write", {127'd0, mem_write}, 128'd1);
        chk("s5 wb mem_addr",  {100'd0, mem_addr},  {100'd0, 28'h10});
        chk("s5 wb mem_wdata", mem_wdata, WB2);
        next_cycle();
        proc_reset_n = 1'b0;
        @(negedge clk);
        chk("s5 pre-rst mem_write", {127'd0, mem_write}, 128'd1);
        next_cycle();
        proc_reset_n = 1'b1;
        drive(1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 128'h0);
        @(negedge clk);
        chk("s5 rst mem_write", {127'd0, mem_write}, 128'd0);
        chk("s5 rst mem_read",  {127'd0, mem_read},  128'd0);
        chk("s5 rst mem_addr",  {100'd0, mem_addr},  128'd0);
        next_cycle();
        // All lines invalid now: 0x12 misses and is refilled from memory.
        drive(1'b1, 1'b0, 30'h12, 32'h0, 1'b0, 128'h0);
        @(negedge clk);
        chk("s5 remiss stall", {127'd0, proc_stall}, 128'd1);
        next_cycle();
        drive(1'b1, 1'b0, 30'h12, 32'h0, 1'b1, F1);
        @(negedge clk);
        chk("s5 alloc mem_read",  {127'd0, mem_read},  128'd1);
        chk("s5 alloc mem_write", {127'd0, mem_write}, 128'd0);
        chk("s5 alloc mem_addr",  {100'd0, mem_addr},  {100'd0, 28'h4});
        next_cycle();
        drive(1'b1, 1'b0, 30'h12, 32'h0, 1'b0, 128'h0);
        @(negedge clk);
        chk("s5 retry stall", {127'd0, proc_stall}, 128'd0);
        chk("s5 retry rdata", {96'd0, proc_rdata}, {96'd0, 32'hDEADBEEF});
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
